phy_lane_scheduler: RTL
=======================

# phy_lane_scheduler

Transmit-side lane scheduler for the four-lane PHY. It buffers the four 9-bit parallel lane words (bit 8 = valid, bits 7:0 = byte) in per-lane FIFOs and emits COM alignment symbols after reset. It then arbitrates the lanes round-robin onto a single byte stream for the serializer, and fills idle slots with IDLE control symbols. It sits between the lane sources (`paralelo0..3`) and the parallel-to-serial stage, and runs in the `clk4f` domain.

## Interface
Parameters:
- `DEPTH`, 4: entries per lane FIFO; power of 2, ≥2.
- `COM_COUNT`, 4: COM symbols emitted after reset release; ≥1.
- `COM`, 8'hBC: alignment control symbol.
- `IDLE`, 8'h7C: filler control symbol.

Ports:
- `clk4f` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = in reset).
- `paralelo0..paralelo3` input 9 each: lane word; bit 8 = valid, bits 7:0 = data.
- `tx_ready` input 1: serializer accepts a symbol at this edge.
- `data_out` output 8: symbol to serializer.
- `k_out` output 1: 1 = control symbol (COM/IDLE), 0 = data.
- `out_valid` output 1: 1 = `data_out` carries a lane data byte.
- `lane_out` output 2: source lane of the current data byte.
- `full` output 4: per-lane FIFO full (count == `DEPTH`).
- `ovf` output 4: sticky per-lane overflow flag.
- `sync_done` output 1: 1 once the COM preamble is complete.

## Operation
- **Enqueue.** At each edge, lane i writes `paralelo_i[7:0]` into FIFO i if `paralelo_i[8]`=1 and `full[i]`=0.
  - Words with bit 8 = 0 are ignored.
  - A valid word arriving while `full[i]`=1 is dropped and sets `ovf[i]`. `ovf` is cleared only by reset.
- **States.**
  - SYNC: entered on reset. On each edge with `tx_ready`=1, emit `COM` with `k_out`=1, `out_valid`=0, `lane_out`=0, and increment the COM counter. After the `COM_COUNT`-th COM, go to RUN and set `sync_done`=1.
  - RUN: on each edge with `tx_ready`=1:
    - Select the first non-empty lane, searching circularly from `rr_ptr`.
    - Pop that lane and register `data_out`=byte, `k_out`=0, `out_valid`=1, `lane_out`=i.
    - Set `rr_ptr`=i+1 (mod 4).
    - If all lanes are empty, emit `IDLE` with `k_out`=1 and `out_valid`=0. `rr_ptr` is unchanged and `lane_out` holds its value.
- **Back-pressure.** With `tx_ready`=0:
  - no pop;
  - the COM counter does not advance;
  - all outputs hold;
  - enqueue continues.
- **FIFOs.** Read/write pointers are log2(`DEPTH`) bits and wrap naturally; the count is log2(`DEPTH`)+1 bits.
  - Simultaneous push and pop on the same lane leaves the count unchanged.
  - Push is refused when the lane is full, even if that lane pops in the same cycle.
  - Arbitration uses the registered counts. A word written at edge N is eligible for pop at edge N+1 at the earliest.
- **Reset.** Assertion at any time, including mid-stream, immediately:
  - clears all FIFOs, `full`, `ovf`, `rr_ptr`=0, and the COM counter;
  - returns to SYNC;
  - forces outputs to their reset values.

  Words in flight are lost.

## Timing
- **Reset values:** `data_out`=8'h7C, `k_out`=1, `out_valid`=0, `lane_out`=0, `full`=0, `ovf`=0, `sync_done`=0.
- **Latency:** a valid word presented before edge N (empty FIFOs, RUN, `tx_ready`=1) appears on `data_out` after edge N+1. That is 1 cycle of buffering plus a registered output.
- **Throughput:** one symbol per `tx_ready` edge. Four simultaneous words drain in 4 consecutive cycles.
- **Preamble:** the first symbol after reset release is COM at the first `tx_ready` edge. `sync_done` rises at the same edge that registers the last COM.
- **Flags:**
  - `full[i]` is registered and reflects the count after the edge.
  - `ovf[i]` sets at the edge of the dropped write.

## Test plan
1. **Reset and preamble.** Hold `reset`=0 for 3 cycles with `tx_ready`=1 → outputs at reset values. Release → 4 cycles of `data_out`=BC with `k_out`=1, `sync_done`=1 on the 4th, then 7C idle.
2. **Single lane.** After sync, drive `paralelo0`=9'h1FF for one cycle → one cycle later `data_out`=FF, `k_out`=0, `out_valid`=1, `lane_out`=0, then idle.
3. **Four lanes in one cycle.** Drive 1FF/1F4/1FA/1F4 on lanes 0-3 → FF(lane 0), F4(lane 1), FA(lane 2), F4(lane 3) on 4 consecutive cycles. A following cycle of 1FE/1FD/1FB/1FF is emitted in the same order with no gap.
4. **Invalid words.** Drive 0FF on lanes 0 and 1 → nothing is enqueued, output stays 7C idle, `ovf`=0.
5. **Overflow and back-pressure.** Set `tx_ready`=0 and push six valid words on lane 2 → `full[2]`=1 after the 4th, `ovf[2]`=1 after the 5th. Raise `tx_ready` → exactly the first 4 words emerge in order, then idle.
6. **Fairness and mid-stream reset.** Push continuously on lanes 0 and 3 → `lane_out` alternates 0,3,0,3. Pull `reset` low mid-stream → outputs go to reset values immediately. On release, `full`=0 and the COM preamble repeats.

Source files
------------

// File: rtl/phy_lane_scheduler.sv
// phy_lane_scheduler: transmit-side lane scheduler for the four-lane PHY.
// Buffers four 9-bit lane words (bit 8 = valid) in per-lane FIFOs, emits a
// COM preamble after reset, then round-robins the lanes onto one byte stream
// toward the serializer, filling empty slots with IDLE control symbols.
//
// Ports:
//   clk4f                 single clock, rising edge
//   reset                 asynchronous active-low reset
//   paralelo0..paralelo3  lane words {valid, byte}
//   tx_ready              serializer consumes a symbol at this edge
//   data_out              symbol to serializer
//   k_out                 1 = control symbol (COM/IDLE)
//   out_valid             1 = data_out carries a lane data byte
//   lane_out              source lane of the current data byte
//   full                  per-lane FIFO full
//   ovf                   sticky per-lane overflow
//   sync_done             COM preamble complete
module phy_lane_scheduler #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned COM_COUNT = 4,
    parameter logic [7:0]  COM       = 8'hBC,
    parameter logic [7:0]  IDLE      = 8'h7C
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic [8:0] paralelo0,
    input  logic [8:0] paralelo1,
    input  logic [8:0] paralelo2,
    input  logic [8:0] paralelo3,
    input  logic       tx_ready,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       out_valid,
    output logic [1:0] lane_out,
    output logic [3:0] full,
    output logic [3:0] ovf,
    output logic       sync_done
);

    localparam int unsigned LANES = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned NW    = $clog2(COM_COUNT + 1);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [8:0]    lane_in   [LANES];
    logic [7:0]    mem       [LANES][DEPTH];
    logic [AW-1:0] wr_ptr    [LANES];
    logic [AW-1:0] rd_ptr    [LANES];
    logic [CW-1:0] count     [LANES];
    logic [CW-1:0] count_nxt [LANES];

    logic [3:0]    push;
    logic [3:0]    pop;
    logic [3:0]    drop;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [NW-1:0] com_cnt;
    logic [NW-1:0] com_cnt_nxt;
    logic [1:0]    rr_ptr;
    logic [1:0]    rr_nxt;

    logic          sel_found;
    logic [1:0]    sel_lane;
    logic [1:0]    idx;

    logic [7:0]    data_nxt;
    logic          k_nxt;
    logic          valid_nxt;
    logic [1:0]    lane_nxt;
    logic          sync_nxt;

    assign lane_in[0] = paralelo0;
    assign lane_in[1] = paralelo1;
    assign lane_in[2] = paralelo2;
    assign lane_in[3] = paralelo3;

    // Enqueue qualification; a valid word against a full lane is dropped even
    // if that lane pops this cycle.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < LANES; i++) begin
            push[i] = lane_in[i][8] & ~full[i];
            drop[i] = lane_in[i][8] &  full[i];
        end
    end

    // Circular search for the first non-empty lane from rr_ptr, using
    // registered counts so a fresh write waits one edge before it can pop.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        idx       = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = rr_ptr + 2'(k);
            if (!sel_found && (count[idx] != '0)) begin
                sel_found = 1'b1;
                sel_lane  = idx;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        com_cnt_nxt = com_cnt;
        rr_nxt      = rr_ptr;
        data_nxt    = data_out;
        k_nxt       = k_out;
        valid_nxt   = out_valid;
        lane_nxt    = lane_out;
        sync_nxt    = sync_done;
        pop         = '0;

        case (state)
            ST_SYNC: begin
                if (tx_ready) begin
                    data_nxt    = COM;
                    k_nxt       = 1'b1;
                    valid_nxt   = 1'b0;
                    lane_nxt    = '0;
                    com_cnt_nxt = com_cnt + NW'(1);
                    if (com_cnt == NW'(COM_COUNT - 1)) begin
                        state_nxt = ST_RUN;
                        sync_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tx_ready) begin
                    if (sel_found) begin
                        pop[sel_lane] = 1'b1;
                        data_nxt      = mem[sel_lane][rd_ptr[sel_lane]];
                        k_nxt         = 1'b0;
                        valid_nxt     = 1'b1;
                        lane_nxt      = sel_lane;
                        rr_nxt        = sel_lane + 2'd1;
                    end else begin
                        // lane_out deliberately keeps the last data lane
                        data_nxt  = IDLE;
                        k_nxt     = 1'b1;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

    // Per-lane occupancy update.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            case ({push[i], pop[i]})
                2'b10:   count_nxt[i] = count[i] + CW'(1);
                2'b01:   count_nxt[i] = count[i] - CW'(1);
                default: count_nxt[i] = count[i];
            endcase
        end
    end

    // FSM state, arbitration pointer and registered outputs.
    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            state     <= ST_SYNC;
            com_cnt   <= '0;
            rr_ptr    <= '0;
            data_out  <= IDLE;
            k_out     <= 1'b1;
            out_valid <= 1'b0;
            lane_out  <= '0;
            sync_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            com_cnt   <= com_cnt_nxt;
            rr_ptr    <= rr_nxt;
            data_out  <= data_nxt;
            k_out     <= k_nxt;
            out_valid <= valid_nxt;
            lane_out  <= lane_nxt;
            sync_done <= sync_nxt;
        end
    end

    // FIFO pointers, counts and flags.
    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            full <= '0;
            ovf  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                count[i] <= count_nxt[i];
                full[i]  <= (count_nxt[i] == CW'(DEPTH));
                ovf[i]   <= ovf[i] | drop[i];
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk4f) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= lane_in[i][7:0];
            end
        end
    end

endmodule
